// File: rtl/button_events_pkg.sv
// button_events_pkg: state encoding and default hold/repeat tick counts shared with the debouncer prescaler
package button_events_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, HELD = 2'b01, LONG = 2'b11} state_e;
  localparam int LONG_TICKS_DEF = 64;
  localparam int REPEAT_TICKS_DEF = 16;
endpackage

// File: rtl/button_events_event_tick_counter.sv
// event_tick_counter: tick counter that clears itself on reaching the terminal value
module event_tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == term_i;
  assign cnt_o = cnt_q;
  always_comb cnt_d = clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/button_events.sv
// button_events: turns a debounced button level into press/release/click/long-press/repeat pulses
module button_events
  import button_events_pkg::*;
#(
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  input  logic en_repeat_i,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic held_o
);
  state_e state_q, state_d;
  logic press_q, press_d, release_q, release_d, click_q, click_d;
  logic long_q, long_d, repeat_q, repeat_d, held_q, held_d;
  logic [CNT_W-1:0] cnt, term;
  logic tc, cnt_en, cnt_clr, hit;
  assign term = (state_q == LONG) ? CNT_W'(REPEAT_TICKS - 1) : CNT_W'(LONG_TICKS - 1);
  assign cnt_en = tick_i && btn_i && (state_q == HELD || (state_q == LONG && en_repeat_i));
  // disabling repeat parks the counter so re-enabling starts a full interval
  assign cnt_clr = !btn_i || state_q == IDLE || (state_q == LONG && !en_repeat_i);
  assign hit = tick_i && tc;
  event_tick_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .term_i(term),
    .cnt_o (cnt),
    .tc_o  (tc)
  );
  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    release_d = 1'b0;
    click_d = 1'b0;
    long_d = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: if (btn_i) begin
        press_d = 1'b1;
        state_d = HELD;
      end
      HELD: if (!btn_i) begin
        release_d = 1'b1;
        click_d = 1'b1;
        state_d = IDLE;
      end else if (hit) begin
        long_d = 1'b1;
        state_d = LONG;
      end
      LONG: if (!btn_i) begin
        release_d = 1'b1;
        state_d = IDLE;
      end else repeat_d = hit && en_repeat_i;
      default: state_d = IDLE;
    endcase
    held_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      press_q <= 1'b0;
      release_q <= 1'b0;
      click_q <= 1'b0;
      long_q <= 1'b0;
      repeat_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      release_q <= release_d;
      click_q <= click_d;
      long_q <= long_d;
      repeat_q <= repeat_d;
      held_q <= held_d;
    end
  end
  assign press_o = press_q;
  assign release_o = release_q;
  assign click_o = click_q;
  assign long_press_o = long_q;
  assign repeat_o = repeat_q;
  assign held_o = held_q;
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= term);
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: randomized + directed scoreboard bench against a hold-duration reference model
module tb_button_events;
  localparam int LT = 4;
  localparam int RT = 2;
  localparam int TP = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_i = 1'b0, btn_i = 1'b0, en_repeat_i = 1'b1;
  logic press_o, release_o, click_o, long_press_o, repeat_o, held_o;
  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  logic [5:0] exp_q[$];
  bit m_down = 0, m_long = 0;
  int m_hold = 0, m_rep = 0;
  string names[6] = '{"held", "repeat", "long_press", "click", "release", "press"};

  button_events #(.LONG_TICKS(LT), .REPEAT_TICKS(RT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .btn_i(btn_i), .en_repeat_i(en_repeat_i),
    .press_o(press_o), .release_o(release_o), .click_o(click_o),
    .long_press_o(long_press_o), .repeat_o(repeat_o), .held_o(held_o)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic drive(input bit r, input bit b, input bit e);
    bit p, rl, c, l, rp, tk;
    @(negedge clk);
    tk = (cyc_n % TP) == TP - 1;
    rst = r; btn_i = b; en_repeat_i = e; tick_i = tk;
    cyc_n++;
    {p, rl, c, l, rp} = '0;
    if (r) begin
      m_down = 0; m_long = 0; m_hold = 0; m_rep = 0;
    end else if (!m_down) begin
      if (b) begin
        p = 1; m_down = 1; m_long = 0; m_hold = 0; m_rep = 0;
      end
    end else if (!b) begin
      rl = 1; c = !m_long; m_down = 0;
    end else if (!m_long) begin
      if (tk) m_hold++;
      if (m_hold == LT) begin
        l = 1; m_long = 1; m_rep = 0;
      end
    end else if (!e) m_rep = 0;
    else if (tk) begin
      m_rep++;
      if (m_rep == RT) begin
        rp = 1; m_rep = 0;
      end
    end
    exp_q.push_back({p, rl, c, l, rp, m_down});
  endtask

  initial begin
    logic [5:0] want, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got = {press_o, release_o, click_o, long_press_o, repeat_o, held_o};
        for (int i = 0; i < 6; i++) begin
          n_cmp++;
          if (got[i] !== want[i]) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b want %b", names[i], n_cmp / 6, got[i], want[i]);
          end
        end
      end
    end
  end

  initial begin
    int t;
    bit b, e;
    repeat (3) drive(1, 1, 1);
    repeat (4) drive(0, 1, 1);
    repeat (3) drive(0, 0, 1);
    repeat (2 * TP) drive(0, 1, 1);
    repeat (3) drive(0, 0, 1);
    repeat (10 * TP + 2) drive(0, 1, 1);
    repeat (3) drive(0, 0, 1);
    repeat (9 * TP) drive(0, 1, 0);
    repeat (3 * TP) drive(0, 1, 1);
    repeat (3) drive(0, 0, 1);
    while (cyc_n % TP != TP - 1) drive(0, 0, 1);
    repeat (6 * TP) drive(0, 1, 1);
    repeat (2) drive(0, 0, 1);
    while (cyc_n % TP != 1) drive(0, 0, 1);
    t = 0;
    forever begin
      if (cyc_n % TP == TP - 1 && t == LT - 1) begin
        drive(0, 0, 1);
        break;
      end
      if (cyc_n % TP == TP - 1) t++;
      drive(0, 1, 1);
    end
    repeat (3) drive(0, 0, 1);
    repeat (6 * TP) drive(0, 1, 1);
    drive(1, 1, 1);
    repeat (2 * TP) drive(0, 1, 1);
    repeat (2) drive(0, 0, 1);
    b = 0; e = 1;
    for (int s = 0; s < 60; s++) begin
      int len;
      len = $urandom_range(1, 70);
      b = !b;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 29) == 0) e = !e;
        drive($urandom_range(0, 299) == 0, b, e);
      end
    end
    repeat (3) drive(0, 0, 1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Sits directly downstream of the button debouncer and consumes its clean `debounced` level.
- Uses the same slow `tick` strobe as the debouncer.
- Turns the held level into one-cycle event pulses: press, release, short click, long press and auto-repeat.
- Downstream control logic sees discrete key events and never has to time the raw level itself.

Parameters:
- LONG_TICKS, 64: number of ticks the button must be held (after press) before long_press fires.
- REPEAT_TICKS, 16: ticks between successive repeat pulses once in long-press state.
- CNT_W, 8: tick counter width; must satisfy 2**CNT_W >= max(LONG_TICKS, REPEAT_TICKS); both counts >= 1.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- tick, input, 1: one-clk strobe from the shared prescaler, same strobe the debouncer uses.
- btn, input, 1: debounced button level, already synchronous to clk; no further synchronisation.
- en_repeat, input, 1: 1 = generate repeat pulses while long-held.
- press, output, 1: one-cycle pulse on press.
- release, output, 1: one-cycle pulse on release.
- click, output, 1: one-cycle pulse on release of a press shorter than LONG_TICKS ticks.
- long_press, output, 1: one-cycle pulse when the hold reaches LONG_TICKS ticks.
- repeat, output, 1: one-cycle pulse every REPEAT_TICKS ticks after long_press.
- held, output, 1: level; 1 while state != IDLE.

Behaviour:
- All outputs are registered. Reset value of every output and of cnt is 0; state resets to IDLE.
- Reset mid-operation: return to IDLE immediately; no release or click pulse is emitted; held=0 the next cycle.
- States: IDLE, HELD, LONG. cnt is a CNT_W-bit tick counter.
- IDLE:
  - btn=1 -> press=1 next cycle, state HELD, cnt=0.
  - tick is ignored in IDLE, including when it coincides with the press cycle.
- HELD:
  - btn=0 -> release=1 and click=1 next cycle, state IDLE, cnt=0.
  - else if tick and cnt==LONG_TICKS-1 -> long_press=1, state LONG, cnt=0.
  - else if tick -> cnt+1.
- LONG:
  - btn=0 -> release=1 (click stays 0), state IDLE, cnt=0.
  - else if tick and en_repeat and cnt==REPEAT_TICKS-1 -> repeat=1, cnt=0.
  - else if tick and en_repeat -> cnt+1.
  - en_repeat=0 -> cnt held at 0. Re-enabling restarts a full REPEAT_TICKS interval.
- Priority: btn=0 beats tick in the same cycle. Releasing on the terminal tick gives click, not long_press.
- Latency: every pulse appears exactly 1 clk after the causing btn/tick cycle.
- Pulse width: every pulse is high for exactly 1 clk, never back-to-back from the same source.
- Ordering: press and release are never high in the same cycle. A minimum press takes 2 clk: press in cycle n+1, release in cycle n+2 or later.
- The counter never wraps. It is cleared at each terminal count, so CNT_W overflow is impossible given the parameter constraint.
- held is 1 from the cycle press is asserted through the cycle before release is asserted; it drops in the same cycle release is asserted.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE=2'b00, HELD=2'b01, LONG=2'b11, unused 2'b10 -> IDLE);
  - the default LONG_TICKS and REPEAT_TICKS constants, shared with the debouncer's tick prescaler configuration.
- One sub-module is natural: event_tick_counter.
  - Inputs: clr, en (tick-qualified), terminal-count value.
  - Outputs: cnt and a tc flag.
  - Instantiated once.
  - The FSM drives clr/en and selects LONG_TICKS-1 or REPEAT_TICKS-1 as the terminal value by state.

Test Plan:
Common setup: LONG_TICKS=4, REPEAT_TICKS=2, tick every 5 clk.
- Reset: hold rst 3 clk with btn=1 -> all outputs 0, held=0. Release rst with btn=1 -> press 1 clk later.
- Short click: btn high 2 ticks, then low -> press once, then release and click together (1 clk each). long_press and repeat stay 0.
- Long press with repeat (en_repeat=1): btn high 10 ticks ->
  - long_press on the 4th tick after press (+1 clk);
  - repeat on the 6th and 8th ticks, then again on the 10th;
  - release with no click on drop.
- Repeat disabled: as the previous case with en_repeat=0 -> long_press once, zero repeat pulses. Raise en_repeat -> first repeat exactly 2 ticks later.
- Simultaneous events:
  - btn falls in the same cycle as the 4th tick in HELD -> click=1, long_press=0.
  - tick coincides with the press cycle -> that tick is not counted; long_press comes 4 further ticks later.
- Reset mid-operation: rst asserted while in LONG -> no release pulse, held=0 next cycle. Then btn still 1 after rst deasserts -> fresh press pulse.
